// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS div/divu with stall, annul and divide-by-zero
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrol,
  input  logic             start,
  input  logic             annul,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             stall,
  output logic             ready,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quot, dvs, nq, nr, abs1, abs2;
  logic [WIDTH:0] sh, diff;
  logic neg_q, neg_r, sgn, dstart;
  assign sgn    = alucontrol == EXE_DIV_OP;
  assign dstart = start & (sgn | (alucontrol == EXE_DIVU_OP));
  assign stall  = dstart & (state != END) & ~annul;
  assign abs1   = (sgn & num1[WIDTH-1]) ? -num1 : num1;
  assign abs2   = (sgn & num2[WIDTH-1]) ? -num2 : num2;
  // one restoring step: shift {rem,quot} left, trial-subtract, keep on no-borrow
  assign sh     = {rem, quot[WIDTH-1]};
  assign diff   = sh - {1'b0, dvs};
  assign nq     = {quot[WIDTH-2:0], ~diff[WIDTH]};
  assign nr     = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  // control FSM with datapath registers and registered results
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quot        <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
    end else if (annul) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (dstart) begin
          dvs         <= abs2;
          quot        <= abs1;
          rem         <= '0;
          cnt         <= '0;
          neg_q       <= sgn & (num1[WIDTH-1] ^ num2[WIDTH-1]);
          neg_r       <= sgn & num1[WIDTH-1];
          div_by_zero <= 1'b0;
          state       <= (num2 == '0) ? ZERO : ON;
        end
        ZERO: begin
          result_lo   <= '0;
          result_hi   <= '0;
          div_by_zero <= 1'b1;
          ready       <= 1'b1;
          state       <= END;
        end
        ON: begin
          quot <= nq;
          rem  <= nr;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            result_lo <= neg_q ? -nq : nq;
            result_hi <= neg_r ? -nr : nr;
            ready     <= 1'b1;
            state     <= END;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table, random and corner-sequence checks of div_unit against an arithmetic model
module tb_div_unit;
  localparam logic [7:0] DIV  = 8'b00011010;
  localparam logic [7:0] DIVU = 8'b00011011;
  logic clk = 0, resetn, start, annul, stall, ready, div_by_zero;
  logic [7:0] alucontrol;
  logic [31:0] num1, num2, result_lo, result_hi, prev_lo, prev_hi;
  int tests = 0, fails = 0;
  typedef struct {logic sgn; logic [31:0] a, b, lo, hi; logic dbz;} vec_t;
  vec_t vt[8];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .alucontrol(alucontrol), .start(start), .annul(annul),
    .num1(num1), .num2(num2), .stall(stall), .ready(ready), .div_by_zero(div_by_zero),
    .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {dbz, hi, lo} from plain integer arithmetic (truncating, remainder takes dividend sign)
  function automatic logic [64:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 0) return {1'b1, 64'd0};
    if (!sgn) return {1'b0, a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
    sa = a;
    sb = b;
    return {1'b0, 32'(sa % sb), 32'(sa / sb)};
  endfunction

  // starts a divide now (cycle 0), holds start until ready, then checks pulse width next cycle
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input logic edbz);
    int lat;
    logic sok;
    alucontrol = sgn ? DIV : DIVU;
    num1 = a;
    num2 = b;
    start = 1;
    lat = 0;
    #1;
    sok = (stall === 1'b1);
    while (ready !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready !== 1'b1) sok &= (stall === 1'b1);
    end
    chk("latency", lat, edbz ? 2 : 33);
    chk("stall_hold", {31'd0, sok}, 1);
    chk("stall_at_ready", {31'd0, stall}, 0);
    chk("result_lo", result_lo, elo);
    chk("result_hi", result_hi, ehi);
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
    start = 0;
    alucontrol = 0;
    @(posedge clk);
    #1;
    chk("ready_pulse", {31'd0, ready}, 0);
    prev_lo = elo;
    prev_hi = ehi;
  endtask

  initial begin
    logic seen;
    logic [64:0] m;
    logic s;
    logic [31:0] a, b;
    vt[0] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 0};
    vt[1] = '{1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0};
    vt[2] = '{1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0};
    vt[3] = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0};
    vt[4] = '{0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0};
    vt[5] = '{0, 32'd5, 32'd0, 32'd0, 32'd0, 1};
    vt[6] = '{0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0};
    vt[7] = '{1, 32'd100, 32'd7, 32'd14, 32'd2, 0};
    resetn = 0; start = 0; annul = 0; alucontrol = 0; num1 = 0; num2 = 0;
    prev_lo = 0; prev_hi = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_dbz", {31'd0, div_by_zero}, 0);
    chk("rst_lo", result_lo, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    resetn = 1;
    @(posedge clk);
    #1;
    // non-divide op with start must not stall or start anything
    alucontrol = 8'h20; start = 1; num1 = 9; num2 = 3;
    #1;
    chk("nondiv_stall", {31'd0, stall}, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    chk("nondiv_ready", {31'd0, seen}, 0);
    start = 0;
    // table vectors, back-to-back
    foreach (vt[i]) run_div(vt[i].sgn, vt[i].a, vt[i].b, vt[i].lo, vt[i].hi, vt[i].dbz);
    // annul mid-divide at cycle 10
    alucontrol = DIVU; num1 = 100; num2 = 7; start = 1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    annul = 1;
    #1;
    chk("stall_annul", {31'd0, stall}, 0);
    @(posedge clk);
    #1;
    annul = 0; start = 0; alucontrol = 0;
    seen |= ready;
    chk("annul_no_ready", {31'd0, seen}, 0);
    chk("annul_lo_kept", result_lo, prev_lo);
    chk("annul_hi_kept", result_hi, prev_hi);
    @(posedge clk);
    #1;
    chk("annul_idle_ready", {31'd0, ready}, 0);
    run_div(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
    // annul together with start in IDLE: not accepted
    alucontrol = DIVU; num1 = 20; num2 = 6; start = 1; annul = 1;
    #1;
    chk("stall_annul_idle", {31'd0, stall}, 0);
    @(posedge clk);
    #1;
    annul = 0;
    run_div(0, 32'd20, 32'd6, 32'd3, 32'd2, 0);
    // asynchronous reset at cycle 15 mid-divide
    alucontrol = DIVU; num1 = 100; num2 = 7; start = 1;
    repeat (15) @(posedge clk);
    #1;
    resetn = 0; start = 0; alucontrol = 0;
    #1;
    chk("arst_ready", {31'd0, ready}, 0);
    chk("arst_lo", result_lo, 0);
    chk("arst_hi", result_hi, 0);
    chk("arst_dbz", {31'd0, div_by_zero}, 0);
    chk("arst_stall", {31'd0, stall}, 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    resetn = 1;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    chk("arst_no_ready", {31'd0, seen}, 0);
    run_div(0, 32'd10, 32'd3, 32'd3, 32'd1, 0);
    // randomized operands against the model
    repeat (40) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1, 2, 3: b = $urandom_range(1, 255);
        4: b = -$urandom_range(1, 255);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      m = model(s, a, b);
      run_div(s, a, b, m[31:0], m[63:32], m[64]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
